// File: rtl/clip_sequencer_pkg.sv
// Shared types and widths for the clip record/playback sequencer.
package clip_sequencer_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LED_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WRITE,
    PLAY_FETCH,
    PLAY_LATCH,
    PLAY_WAIT
  } seq_state_t;

endpackage

// File: rtl/clip_sequencer_if.sv
// Block-RAM access bus between the sequencer (master) and the two sample banks (slave).
interface clip_sequencer_if #(
  parameter int unsigned ADDR_W = 17
);
  import clip_sequencer_pkg::*;

  logic                mem_en;
  logic                mem_we;
  logic                mem_bank;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [SAMPLE_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_bank, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_bank, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/clip_sequencer_edge_detect.sv
// Registered rising-edge detector for a synchronized command level.
module edge_detect (
  input  logic clock_i,
  input  logic reset_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  // Track the level every cycle (including reset) so a level held through reset never fires.
  always_ff @(posedge clock_i) begin
    prev_q <= level_i;
    if (reset_i) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= level_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/clip_sequencer.sv
// Record/playback sequencer: moves samples between deserializer, two RAM banks and serializer.
module clip_sequencer
  import clip_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned CLIP_LEN = 131072
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                play_command_i,
  input  logic                record_command_i,
  input  logic                play_clip_select_i,
  input  logic                record_clip_select_i,
  input  logic                deserializer_done_i,
  input  logic [SAMPLE_W-1:0] deserializer_data_i,
  output logic                deserializer_enable_o,
  input  logic                serializer_done_i,
  output logic                serializer_enable_o,
  output logic                serializer_load_o,
  output logic [SAMPLE_W-1:0] serializer_data_o,
  clip_sequencer_if.master    mem,
  output logic [LED_W-1:0]    play_clip_o,
  output logic [LED_W-1:0]    record_clip_o,
  output logic                busy_o
);

  // Lengths need one more bit than addresses when CLIP_LEN == 2**ADDR_W.
  localparam int unsigned         LEN_W     = $clog2(CLIP_LEN + 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(CLIP_LEN - 1);

  seq_state_t          state_q, state_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [LEN_W-1:0]    len_q [2];
  logic [LEN_W-1:0]    len_d [2];
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] sdata_q, sdata_d;

  logic play_edge;
  logic rec_edge;
  logic playing;
  logic recording;

  edge_detect u_play_edge (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (play_command_i),
    .pulse_o (play_edge)
  );

  edge_detect u_rec_edge (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (record_command_i),
    .pulse_o (rec_edge)
  );

  // State, counters, bank lengths and sample holding registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      bank_q   <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      len_q    <= '{default: '0};
      sample_q <= '0;
      sdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      len_q    <= len_d;
      sample_q <= sample_d;
      sdata_q  <= sdata_d;
    end
  end

  // Next-state logic: command acceptance, record/playback stepping and aborts.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    len_d    = len_q;
    sample_d = sample_q;
    sdata_d  = sdata_q;
    unique case (state_q)
      IDLE: begin
        if (rec_edge) begin
          bank_d  = record_clip_select_i;
          waddr_d = '0;
          state_d = REC_WAIT;
        end else if (play_edge) begin
          bank_d = play_clip_select_i;
          if (len_q[play_clip_select_i] != '0) begin
            raddr_d = '0;
            state_d = PLAY_FETCH;
          end
        end
      end
      REC_WAIT: begin
        if (rec_edge) begin
          len_d[bank_q] = LEN_W'(waddr_q);
          state_d       = IDLE;
        end else if (deserializer_done_i) begin
          sample_d = deserializer_data_i;
          state_d  = REC_WRITE;
        end
      end
      REC_WRITE: begin
        // The write issued this cycle always counts, whether stopping or filling up.
        if (rec_edge || (waddr_q == LAST_ADDR)) begin
          len_d[bank_q] = LEN_W'(waddr_q) + LEN_W'(1);
          state_d       = IDLE;
        end else begin
          waddr_d = waddr_q + ADDR_W'(1);
          state_d = REC_WAIT;
        end
      end
      PLAY_FETCH: begin
        state_d = play_edge ? IDLE : PLAY_LATCH;
      end
      PLAY_LATCH: begin
        sdata_d = mem.mem_rdata;
        state_d = play_edge ? IDLE : PLAY_WAIT;
      end
      PLAY_WAIT: begin
        if (play_edge) begin
          state_d = IDLE;
        end else if (serializer_done_i) begin
          if ((LEN_W'(raddr_q) + LEN_W'(1)) == len_q[bank_q]) begin
            state_d = IDLE;
          end else begin
            raddr_d = raddr_q + ADDR_W'(1);
            state_d = PLAY_FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore-style outputs decoded from the current state.
  always_comb begin
    recording = (state_q == REC_WAIT) || (state_q == REC_WRITE);
    playing   = (state_q == PLAY_FETCH) || (state_q == PLAY_LATCH) || (state_q == PLAY_WAIT);

    busy_o                = (state_q != IDLE);
    deserializer_enable_o = recording;
    serializer_enable_o   = playing;
    serializer_load_o     = (state_q == PLAY_LATCH);
    serializer_data_o     = (state_q == PLAY_LATCH) ? mem.mem_rdata : sdata_q;

    mem.mem_en    = (state_q == REC_WRITE) || (state_q == PLAY_FETCH);
    mem.mem_we    = (state_q == REC_WRITE);
    mem.mem_bank  = busy_o ? bank_q : 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_q == REC_WRITE) begin
      mem.mem_addr  = waddr_q;
      mem.mem_wdata = sample_q;
    end else if (state_q == PLAY_FETCH) begin
      mem.mem_addr = raddr_q;
    end

    play_clip_o   = '0;
    record_clip_o = '0;
    if (state_q == IDLE) begin
      play_clip_o   = LED_W'(play_clip_select_i);
      record_clip_o = LED_W'(record_clip_select_i);
    end else if (playing) begin
      play_clip_o = LED_W'(bank_q);
    end else begin
      record_clip_o = LED_W'(bank_q);
    end
  end

endmodule

// File: tb/tb_clip_sequencer.sv
// Directed bench for clip_sequencer with a small 8-sample clip and a two-bank RAM model.
module tb_clip_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned CL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        play, rec, psel, rsel, ddone, sdone;
  logic [15:0] ddata;
  logic        de_en, se_en, se_load, busy;
  logic [15:0] se_data;
  logic [3:0]  pclip, rclip;

  always #5 clk = ~clk;

  clip_sequencer_if #(.ADDR_W(AW)) mem_if ();

  clip_sequencer #(.ADDR_W(AW), .CLIP_LEN(CL)) dut (
    .clock_i               (clk),
    .reset_i               (rst),
    .play_command_i        (play),
    .record_command_i      (rec),
    .play_clip_select_i    (psel),
    .record_clip_select_i  (rsel),
    .deserializer_done_i   (ddone),
    .deserializer_data_i   (ddata),
    .deserializer_enable_o (de_en),
    .serializer_done_i     (sdone),
    .serializer_enable_o   (se_en),
    .serializer_load_o     (se_load),
    .serializer_data_o     (se_data),
    .mem                   (mem_if),
    .play_clip_o           (pclip),
    .record_clip_o         (rclip),
    .busy_o                (busy)
  );

  // RAM model with one-cycle read latency, plus access counters.
  logic [15:0] bank_mem [2][16];
  int wr_cnt = 0, rd_cnt = 0, ld_cnt = 0, b2b_cnt = 0;
  logic en_prev = 1'b0;

  always @(posedge clk) begin
    if (mem_if.mem_en) begin
      if (mem_if.mem_we) begin
        bank_mem[mem_if.mem_bank][mem_if.mem_addr] <= mem_if.mem_wdata;
        wr_cnt++;
      end else begin
        mem_if.mem_rdata <= bank_mem[mem_if.mem_bank][mem_if.mem_addr];
        rd_cnt++;
      end
    end
    if (se_load) ld_cnt++;
    if (mem_if.mem_en && en_prev) b2b_cnt++;
    en_prev = mem_if.mem_en;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [34:0] mk(input logic b, d, s, l, e, w, k,
                                     input logic [3:0] a, input logic [15:0] wd,
                                     input logic [3:0] pc, input logic [3:0] rc);
    return {b, d, s, l, e, w, k, a, wd, pc, rc};
  endfunction

  function automatic logic [34:0] out_now();
    return {busy, de_en, se_en, se_load, mem_if.mem_en, mem_if.mem_we, mem_if.mem_bank,
            mem_if.mem_addr, mem_if.mem_wdata, pclip, rclip};
  endfunction

  typedef struct {
    logic        play;
    logic        rec;
    logic        dd;
    logic [15:0] dd_data;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic play_bank(input logic b, input int n, input logic [15:0] base);
    int rd0;
    int w;
    rd0  = rd_cnt;
    psel = b;
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!mem_if.mem_en && w < 6) begin
        tick();
        w++;
      end
      chk($sformatf("play%0d_read%0d", b, k),
          {mem_if.mem_en, mem_if.mem_we, mem_if.mem_bank, mem_if.mem_addr},
          {1'b1, 1'b0, b, AW'(k)});
      tick();
      chk($sformatf("play%0d_load%0d", b, k), {se_load, se_data}, {1'b1, 16'(base + k)});
      tick();
      chk($sformatf("play%0d_wait%0d", b, k), {se_en, se_load, mem_if.mem_en}, 3'b100);
      sdone = 1'b1;
      tick();
      sdone = 1'b0;
    end
    chk($sformatf("play%0d_idle", b), busy, 1'b0);
    chk($sformatf("play%0d_reads", b), rd_cnt - rd0, n);
  endtask

  task automatic expect_no_play(input logic b, input string name);
    int rd0, ld0;
    logic busy_seen;
    rd0 = rd_cnt;
    ld0 = ld_cnt;
    busy_seen = 1'b0;
    psel = b;
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int i = 0; i < 6; i++) begin
      busy_seen |= busy;
      tick();
    end
    chk({name, "_activity"}, {busy_seen, 32'(rd_cnt - rd0), 32'(ld_cnt - ld0)}, '0);
  endtask

  initial begin
    int wr0;
    int w;
    logic busy_seen;

    rst = 1'b1; play = 1'b0; rec = 1'b0; psel = 1'b1; rsel = 1'b0;
    ddone = 1'b0; sdone = 1'b0; ddata = '0;
    tick();
    tick();
    chk("reset_outputs", out_now(), mk(0,0,0,0,0,0,0,4'd0,16'h0,4'd1,4'd0));
    chk("reset_ser_data", se_data, 16'h0);
    rst = 1'b0;
    tick();

    // Play from an empty bank straight after reset does nothing.
    expect_no_play(1'b0, "empty_bank0");

    // Basic record of 3 samples into bank 1, with a play edge mid-record that must be ignored.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, mk(0,0,0,0,0,0,0,4'd0,16'h0000,4'd1,4'd1)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, mk(0,0,0,0,0,0,0,4'd0,16'h0000,4'd1,4'd1)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0001, mk(1,1,0,0,0,0,1,4'd0,16'h0000,4'd0,4'd1)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, mk(1,1,0,0,1,1,1,4'd0,16'h0001,4'd0,4'd1)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, mk(1,1,0,0,0,0,1,4'd0,16'h0000,4'd0,4'd1)};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, mk(1,1,0,0,1,1,1,4'd1,16'h0002,4'd0,4'd1)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0003, mk(1,1,0,0,0,0,1,4'd0,16'h0000,4'd0,4'd1)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, mk(1,1,0,0,1,1,1,4'd2,16'h0003,4'd0,4'd1)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, mk(1,1,0,0,0,0,1,4'd0,16'h0000,4'd0,4'd1)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, mk(1,1,0,0,0,0,1,4'd0,16'h0000,4'd0,4'd1)};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, mk(0,0,0,0,0,0,0,4'd0,16'h0000,4'd1,4'd1)};
    psel = 1'b1;
    rsel = 1'b1;
    for (int i = 0; i < 11; i++) begin
      play  = vecs[i].play;
      rec   = vecs[i].rec;
      ddone = vecs[i].dd;
      ddata = vecs[i].dd_data;
      #1;
      chk($sformatf("rec_vec%0d", i), out_now(), vecs[i].exp);
      tick();
    end
    chk("rec_write_count", wr_cnt, 3);

    // Play back the 3 recorded samples from bank 1.
    play_bank(1'b1, 3, 16'h0001);

    // Simultaneous edges in IDLE: record wins; then abort with zero samples written.
    psel = 1'b1;
    rsel = 1'b0;
    play = 1'b1;
    rec  = 1'b1;
    tick();
    play = 1'b0;
    rec  = 1'b0;
    tick();
    chk("simul_record_wins", out_now(), mk(1,1,0,0,0,0,0,4'd0,16'h0,4'd0,4'd0));
    chk("simul_no_read", rd_cnt, 3);
    rec = 1'b1;
    tick();
    rec = 1'b0;
    tick();
    tick();
    chk("abort_empty_idle", {busy, 32'(wr_cnt)}, {1'b0, 32'd3});

    // Full clip into bank 0: auto-stop after address 7, a 9th done pulse writes nothing.
    rsel = 1'b0;
    rec  = 1'b1;
    tick();
    rec = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      ddone = 1'b1;
      ddata = 16'(16'h0010 + i);
      tick();
      ddone = 1'b0;
      chk($sformatf("full_write%0d", i), out_now(),
          mk(1,1,0,0,1,1,0,AW'(i),16'(16'h0010 + i),4'd0,4'd0));
      tick();
    end
    chk("full_auto_idle", {busy, de_en}, 2'b00);
    wr0   = wr_cnt;
    ddone = 1'b1;
    ddata = 16'h00ff;
    tick();
    ddone = 1'b0;
    tick();
    chk("full_extra_done_ignored", {busy, 32'(wr_cnt - wr0)}, '0);

    play_bank(1'b0, 8, 16'h0010);

    // Reset in PLAY_WAIT with the play level held high across reset.
    psel = 1'b0;
    rsel = 1'b1;
    play = 1'b1;
    tick();
    w = 0;
    while (!(se_en && !se_load && !mem_if.mem_en) && w < 8) begin
      tick();
      w++;
    end
    chk("rst_in_play_wait", {busy, se_en, se_load, mem_if.mem_en}, 4'b1100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_outputs", out_now(), mk(0,0,0,0,0,0,0,4'd0,16'h0,4'd0,4'd1));
    chk("rst_ser_data", se_data, 16'h0);
    busy_seen = 1'b0;
    wr0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      busy_seen |= busy;
      tick();
    end
    chk("held_play_no_fire", {busy_seen, 32'(rd_cnt - wr0)}, '0);
    play = 1'b0;
    tick();
    expect_no_play(1'b0, "len0_cleared");
    expect_no_play(1'b1, "len1_cleared");

    chk("total_writes", wr_cnt, 11);
    chk("no_back_to_back_mem_en", b2b_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
